// File: rtl/mem_dma_if.sv
// Bundle of request/status and memory-port signals for mem_dma.
// master is the DMA engine's view; slave is the requester + memory view.
interface mem_dma_if #(
  parameter int AW = 5
);
  logic          start;
  logic          mode;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [AW:0]   len;
  logic [31:0]   fill_val;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_we;
  logic [31:0]   mem_rdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   count;

  modport master (
    input  start, mode, src, dst, len, fill_val, mem_rdata,
    output mem_addr, mem_wdata, mem_we, busy, done, err, count
  );

  modport slave (
    output start, mode, src, dst, len, fill_val, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, busy, done, err, count
  );
endinterface

// File: rtl/mem_dma.sv
// Word-granular copy/fill engine that owns the data-memory port while busy.
// Request handshake: start is a level sampled only in IDLE; done/err pulse one cycle in FIN.
module mem_dma #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_dma_if.master      bus,
  output logic [1:0]     dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, FIN = 2'd3} state_t;

  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);
  localparam logic [AW:0]   ONE     = (AW+1)'(1);

  state_t        state, state_next;
  logic          mode_q;
  logic [AW-1:0] src_q, dst_q;
  logic [AW:0]   len_q, idx_q, count_q;
  logic [31:0]   fill_q, buf_q;
  logic          err_q;

  logic [AW+1:0] dst_end, src_end;
  logic          reject;
  logic [AW:0]   idx_next;
  logic [AW-1:0] addr_idx;

  // Range check in AW+2 bits so DEPTH itself and overflow are representable.
  assign dst_end = {2'b00, bus.dst} + {1'b0, bus.len};
  assign src_end = {2'b00, bus.src} + {1'b0, bus.len};
  assign reject  = (dst_end > DEPTH_W) || (!bus.mode && (src_end > DEPTH_W));
  assign idx_next = idx_q + ONE;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (reject || bus.len == '0) state_next = FIN;
          else if (bus.mode)           state_next = WR;
          else                         state_next = RD;
        end
      end
      RD:  state_next = WR;
      WR: begin
        if (idx_next == len_q) state_next = FIN;
        else if (mode_q)       state_next = WR;
        else                   state_next = RD;
      end
      FIN: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      mode_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      count_q <= '0;
      fill_q  <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mode_q  <= bus.mode;
            src_q   <= bus.src;
            dst_q   <= bus.dst;
            len_q   <= bus.len;
            fill_q  <= bus.fill_val;
            idx_q   <= '0;
            count_q <= '0;
            err_q   <= reject;
          end
        end
        RD: buf_q <= bus.mem_rdata;
        WR: begin
          idx_q   <= idx_next;
          count_q <= count_q + ONE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    addr_idx = '0;
    if (state == RD)      addr_idx = src_q + idx_q[AW-1:0];
    else if (state == WR) addr_idx = dst_q + idx_q[AW-1:0];
  end

  assign bus.mem_addr  = {{(32-AW){1'b0}}, addr_idx};
  assign bus.mem_wdata = (state == WR) ? (mode_q ? fill_q : buf_q) : 32'h0;
  // Gated by rst_n so a reset asserted mid-write suppresses that cycle's write.
  assign bus.mem_we    = (state == WR) && rst_n;
  assign bus.busy      = (state == RD) || (state == WR);
  assign bus.done      = (state == FIN);
  assign bus.err       = (state == FIN) && err_q;
  assign bus.count     = count_q;
  assign dbg_state     = state;
endmodule

// File: tb/tb_mem_dma.sv
// Directed bench for mem_dma: drives requests, models the 32x32 memory, checks
// latency, counts, memory contents, boundaries, reset abort and held start.
module tb_mem_dma;
  logic        clk;
  logic        rst_n;
  logic [1:0]  dbg_state;
  logic [31:0] mem [32];
  int          tests;
  int          fails;
  int          bc, wc, dc;
  logic        es;

  mem_dma_if #(.AW(5)) bus();

  mem_dma #(.DEPTH(32), .AW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: synchronous write, combinational read
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[4:0]] <= bus.mem_wdata;
  end
  assign bus.mem_rdata = mem[bus.mem_addr[4:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: present a request at a negedge, sampled at the next posedge (edge k)
  task automatic launch(input logic m, input logic [4:0] s, input logic [4:0] d,
                        input logic [5:0] l, input logic [31:0] f, input bit hold);
    @(negedge clk);
    bus.mode = m; bus.src = s; bus.dst = d; bus.len = l; bus.fill_val = f;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
  endtask

  // observe cycles k+1.. until done; returns busy cycles, write cycles, done cycle, err
  task automatic observe(output int busy_c, output int we_c, output int done_c, output logic err_s);
    busy_c = 0; we_c = 0; done_c = -1; err_s = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (bus.busy)   busy_c++;
      if (bus.mem_we) we_c++;
      if (bus.done) begin
        done_c = c;
        err_s  = bus.err;
        break;
      end
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.mode = 1'b0; bus.src = '0; bus.dst = '0;
    bus.len = '0; bus.fill_val = '0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000 + i;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'b0, bus.busy}, 32'h0);
    chk("rst_done", {31'b0, bus.done}, 32'h0);
    chk("rst_err", {31'b0, bus.err}, 32'h0);
    chk("rst_count", {26'b0, bus.count}, 32'h0);
    chk("rst_we", {31'b0, bus.mem_we}, 32'h0);
    chk("rst_addr", bus.mem_addr, 32'h0);
    chk("rst_wdata", bus.mem_wdata, 32'h0);
    chk("rst_state", {30'b0, dbg_state}, 32'h0);
    rst_n = 1'b1;

    // copy 4 words 0..3 -> 8..11
    for (int i = 0; i < 4; i++) mem[i] = 32'hA0 + i;
    launch(1'b0, 5'd0, 5'd8, 6'd4, 32'h0, 1'b0);
    observe(bc, wc, dc, es);
    chk("copy_busy", bc, 8);
    chk("copy_done_cyc", dc, 9);
    chk("copy_err", {31'b0, es}, 32'h0);
    chk("copy_count", {26'b0, bus.count}, 32'h4);
    @(negedge clk);
    chk("copy_m8", mem[8], 32'hA0);
    chk("copy_m9", mem[9], 32'hA1);
    chk("copy_m10", mem[10], 32'hA2);
    chk("copy_m11", mem[11], 32'hA3);
    chk("copy_m12", mem[12], 32'h100C);
    chk("copy_src0", mem[0], 32'hA0);
    chk("copy_src3", mem[3], 32'hA3);
    chk("count_hold", {26'b0, bus.count}, 32'h4);

    // fill 3 words at 20
    launch(1'b1, 5'd0, 5'd20, 6'd3, 32'hDEADBEEF, 1'b0);
    observe(bc, wc, dc, es);
    chk("fill_busy", bc, 3);
    chk("fill_done_cyc", dc, 4);
    chk("fill_count", {26'b0, bus.count}, 32'h3);
    @(negedge clk);
    chk("fill_m19", mem[19], 32'h1013);
    chk("fill_m20", mem[20], 32'hDEADBEEF);
    chk("fill_m22", mem[22], 32'hDEADBEEF);
    chk("fill_m23", mem[23], 32'h1017);

    // len = 0
    launch(1'b0, 5'd0, 5'd4, 6'd0, 32'h0, 1'b0);
    observe(bc, wc, dc, es);
    chk("len0_done_cyc", dc, 1);
    chk("len0_err", {31'b0, es}, 32'h0);
    chk("len0_busy", bc, 0);
    chk("len0_we", wc, 0);
    chk("len0_count", {26'b0, bus.count}, 32'h0);

    // rejected copy: src 30 + 4 > 32
    launch(1'b0, 5'd30, 5'd0, 6'd4, 32'h0, 1'b0);
    observe(bc, wc, dc, es);
    chk("rej_src_done_cyc", dc, 1);
    chk("rej_src_err", {31'b0, es}, 32'h1);
    chk("rej_src_we", wc, 0);
    chk("rej_src_m0", mem[0], 32'hA0);

    // rejected fill: dst 30 + 3 > 32
    launch(1'b1, 5'd0, 5'd30, 6'd3, 32'h99, 1'b0);
    observe(bc, wc, dc, es);
    chk("rej_dst_err", {31'b0, es}, 32'h1);
    chk("rej_dst_we", wc, 0);

    // fill at the top index
    launch(1'b1, 5'd0, 5'd31, 6'd1, 32'h77, 1'b0);
    observe(bc, wc, dc, es);
    chk("top_busy", bc, 1);
    chk("top_done_cyc", dc, 2);
    chk("top_err", {31'b0, es}, 32'h0);
    @(negedge clk);
    chk("top_m31", mem[31], 32'h77);
    chk("top_m30", mem[30], 32'h101E);

    // overlapping copy replicates the first word
    for (int i = 0; i < 4; i++) mem[i] = i + 1;
    launch(1'b0, 5'd0, 5'd1, 6'd3, 32'h0, 1'b0);
    observe(bc, wc, dc, es);
    chk("ovl_busy", bc, 6);
    chk("ovl_done_cyc", dc, 7);
    @(negedge clk);
    chk("ovl_m0", mem[0], 32'h1);
    chk("ovl_m1", mem[1], 32'h1);
    chk("ovl_m2", mem[2], 32'h1);
    chk("ovl_m3", mem[3], 32'h1);

    // reset during the 3rd WR cycle of a fill
    for (int i = 0; i < 8; i++) mem[i] = 32'h2000 + i;
    launch(1'b1, 5'd0, 5'd0, 6'd8, 32'h5, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy_before", {31'b0, bus.busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_we_gated", {31'b0, bus.mem_we}, 32'h0);
    @(negedge clk);
    chk("mid_rst_state", {30'b0, dbg_state}, 32'h0);
    chk("mid_rst_busy", {31'b0, bus.busy}, 32'h0);
    chk("mid_rst_count", {26'b0, bus.count}, 32'h0);
    chk("mid_rst_addr", bus.mem_addr, 32'h0);
    rst_n = 1'b1;
    chk("mid_m0", mem[0], 32'h5);
    chk("mid_m1", mem[1], 32'h5);
    chk("mid_m2", mem[2], 32'h2002);
    chk("mid_m7", mem[7], 32'h2007);
    launch(1'b1, 5'd0, 5'd0, 6'd2, 32'h9, 1'b0);
    observe(bc, wc, dc, es);
    chk("post_busy", bc, 2);
    chk("post_done_cyc", dc, 3);
    @(negedge clk);
    chk("post_m1", mem[1], 32'h9);
    chk("post_m2", mem[2], 32'h2002);

    // start held high: parameters change mid-transfer, second run uses them
    mem[0] = 32'h11; mem[1] = 32'h22;
    launch(1'b0, 5'd0, 5'd4, 6'd2, 32'h0, 1'b1);
    bus.mode = 1'b1; bus.dst = 5'd10; bus.len = 6'd1; bus.fill_val = 32'h55;
    observe(bc, wc, dc, es);
    chk("hold1_busy", bc, 4);
    chk("hold1_done_cyc", dc, 5);
    chk("hold1_m4", mem[4], 32'h11);
    chk("hold1_m5", mem[5], 32'h22);
    chk("hold1_m10", mem[10], 32'hA2);
    @(negedge clk);
    chk("hold_idle_state", {30'b0, dbg_state}, 32'h0);
    chk("hold_idle_busy", {31'b0, bus.busy}, 32'h0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    observe(bc, wc, dc, es);
    chk("hold2_busy", bc, 1);
    chk("hold2_done_cyc", dc, 2);
    chk("hold2_count", {26'b0, bus.count}, 32'h1);
    @(negedge clk);
    chk("hold2_m10", mem[10], 32'h55);
    chk("hold2_m5", mem[5], 32'h22);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_dma.md
# mem_dma

Word-granular block-transfer engine that drives the data-memory port (word-indexed 32×32 memory, synchronous write, combinational read) as its initiator. It copies a run of words from one memory region to another, or fills a region with a constant, without processor involvement. It sits beside the datapath on the memory's address/data/write-enable inputs and consumes the memory's combinational read output. Arbitration against the processor is external; while `busy` is high this block owns the port.

## Interface
Parameters:
- `DEPTH`, 32: memory depth in words.
- `AW`, 5: word-index width; must satisfy 2^AW = DEPTH.

Ports:
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `start`  in  1: request; sampled only in IDLE.
- `mode`  in  1: 0 = copy, 1 = fill; sampled with `start`.
- `src`  in  AW: source start index (copy only).
- `dst`  in  AW: destination start index.
- `len`  in  AW+1: word count, 0..DEPTH.
- `fill_val`  in  32: fill constant; sampled with `start`.
- `mem_addr`  out  32: word index to memory, zero-extended.
- `mem_wdata`  out  32: write data to memory.
- `mem_we`  out  1: memory write enable.
- `mem_rdata`  in  32: combinational read data from memory.
- `busy`  out  1: transfer in progress.
- `done`  out  1: one-cycle completion pulse.
- `err`  out  1: one-cycle pulse, coincident with `done`, on a rejected request.
- `count`  out  AW+1: words written by the last or current transfer.

## Operation
- States: IDLE, RD, WR, FIN.
- IDLE: if `start`=1, latch `mode`, `src`, `dst`, `len`, and `fill_val`, and clear `count`.
  - Range check uses AW+2-bit sums: reject if `dst+len > DEPTH`, or if copy and `src+len > DEPTH`. Rejected → FIN with `err`=1. No memory write occurs.
  - `len`=0 → FIN, no error, no write.
  - Otherwise copy → RD; fill → WR.
- RD (copy): `mem_addr`=src+i, `mem_we`=0. Register `mem_rdata` into an internal buffer at the clock edge, then go to WR.
- WR: `mem_addr`=dst+i, `mem_we`=1. `mem_wdata` = buffer (copy) or `fill_val` (fill). At the edge, i and `count` increment.
  - If i+1 = len → FIN.
  - Else copy → RD, fill stays in WR.
- FIN: `done`=1 for one cycle; `err` asserted if the request was rejected. Next state is IDLE.
- Transfers always run in ascending index order. When a copy overlaps with dst > src, already-written words are re-read; the resulting replication is the defined behaviour.
- `start` outside IDLE is ignored; parameters are not re-sampled.
- Outside RD/WR: `mem_addr`=0, `mem_wdata`=0, `mem_we`=0.
- All outputs are registered-state decodes, with no combinational path from `start` to the memory outputs.

## Timing
- Reset (`rst_n`=0 at an edge): after that edge, state is IDLE and `busy`=0, `done`=0, `err`=0, `count`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - Reset mid-transfer aborts immediately. Words already written stay written; no further writes occur.
- `busy`=1 exactly in RD and WR; it is low in IDLE and FIN.
- Latency, with `start` sampled at edge k:
  - Copy of L words: busy cycles k+1..k+2L; `done` in cycle k+2L+1.
  - Fill of L words: busy cycles k+1..k+L; `done` in cycle k+L+1.
  - `len`=0 or rejected request: `done` (with `err` if rejected) in cycle k+1; no busy cycles.
- A new `start` is accepted at the edge ending the IDLE cycle that follows FIN. Back-to-back gap from `done` to next acceptance is therefore 1 cycle minimum.
- `count` holds its final value until the next accepted `start`.
- Max legal transfer: `len`=DEPTH with start index 0. `dst`=31 with `len`=1 is legal.

## Test plan
- Copy: preload mem[0..3]=0xA0..0xA3; start with copy, src=0, dst=8, len=4. Expect mem[8..11]=0xA0..0xA3, 8 busy cycles, `done` in cycle 9, `count`=4, mem[0..3] unchanged.
- Fill: fill, dst=20, len=3, fill_val=0xDEADBEEF. Expect mem[20..22]=0xDEADBEEF, mem[19] and mem[23] unchanged, 3 busy cycles, `count`=3.
- Boundaries: `len`=0 gives `done` next cycle, `err`=0, no `mem_we`. Copy with src=30, len=4 gives `done`+`err` next cycle and no writes. Fill with dst=31, len=1 writes mem[31] only.
- Overlap: mem[0..3]=1,2,3,4; copy src=0, dst=1, len=3. Expect mem[0..3]=1,1,1,1.
- Reset mid-op: fill dst=0, len=8 with fill_val=5; drive `rst_n`=0 during the 3rd WR cycle. Expect mem[0..1]=5, mem[2..7] unchanged, and after the reset edge all outputs 0 and state IDLE. A subsequent fill then runs normally.
- `start` held high throughout a copy: exactly one transfer runs, then a second is accepted in the IDLE cycle after `done`, using the parameters present at that edge.
